// File: rtl/decodificador_servo.sv
// Servo PWM receiver: measures each high pulse and decodes it to a 2-bit position code.
// Latency: valido 3 cycles after the input falls (+FILTRO_CICLOS when DECOD_SERVO_FILTRO_EN is defined).
// Backpressure: none; free-running receiver, valido is a single-cycle strobe.
module decodificador_servo #(
  parameter int LARG_01       = 50_000,
  parameter int LARG_10       = 75_000,
  parameter int LARG_11       = 100_000,
  parameter int TOL           = 2_500,
  parameter int TIMEOUT       = 1_100_000,
  parameter int N             = 21,
  parameter int FILTRO_CICLOS = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         pwm,
  output logic [1:0]   posicao,
  output logic [N-1:0] largura,
  output logic         valido,
  output logic         erro,
  output logic         sem_sinal,
  output logic [1:0]   db_estado
);

  typedef enum logic [1:0] {
    INICIAL = 2'b00,
    ALTO    = 2'b01,
    BAIXO   = 2'b10,
    PRESO   = 2'b11
  } estado_t;

  estado_t     estado;
  logic        pwm_m;
  logic        pwm_s;
  logic        pwm_f;
  logic        pwm_d;
  logic        subida;
  logic        descida;
  logic [N-1:0] larg_cnt;
  logic [N-1:0] tmo_cnt;
  logic        tmo_evt;
  logic [1:0]  cod;
  logic        casou;

  // Two-flop synchronizer. Resets to 1 so that a pulse already high at
  // reset release never looks like a rising edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm_m <= 1'b1;
      pwm_s <= 1'b1;
    end else begin
      pwm_m <= pwm;
      pwm_s <= pwm_m;
    end
  end

`ifdef DECOD_SERVO_FILTRO_EN
  localparam int FW = $clog2(FILTRO_CICLOS + 1);
  logic [FW-1:0] flt_cnt;

  // Glitch filter: follow pwm_s only after it holds a new level for FILTRO_CICLOS cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm_f   <= 1'b1;
      flt_cnt <= '0;
    end else if (pwm_s == pwm_f) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FW'(FILTRO_CICLOS - 1)) begin
      pwm_f   <= pwm_s;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end
`else
  assign pwm_f = pwm_s;
`endif

  // Previous filtered level for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pwm_d <= 1'b1;
    else        pwm_d <= pwm_f;
  end

  assign subida  =  pwm_f & ~pwm_d;
  assign descida = ~pwm_f &  pwm_d;

  // Loss-of-signal counter: cleared by every rise, holds once TIMEOUT is reached.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                       tmo_cnt <= '0;
    else if (subida)                  tmo_cnt <= '0;
    else if (tmo_cnt != N'(TIMEOUT))  tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Fires on the single edge where the counter lands on TIMEOUT.
  assign tmo_evt = !subida && (tmo_cnt == N'(TIMEOUT - 1));

  function automatic logic perto(input int w, input int nom);
    return (w >= nom - TOL) && (w <= nom + TOL);
  endfunction

  // Match the running width against the three inclusive tolerance windows.
  always_comb begin
    cod   = 2'b00;
    casou = 1'b0;
    if (perto(int'(larg_cnt), LARG_01)) begin
      cod   = 2'b01;
      casou = 1'b1;
    end else if (perto(int'(larg_cnt), LARG_10)) begin
      cod   = 2'b10;
      casou = 1'b1;
    end else if (perto(int'(larg_cnt), LARG_11)) begin
      cod   = 2'b11;
      casou = 1'b1;
    end
  end

  // Main FSM: width measurement, classification and timeout reporting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= INICIAL;
      larg_cnt  <= '0;
      posicao   <= 2'b00;
      largura   <= '0;
      valido    <= 1'b0;
      erro      <= 1'b0;
      sem_sinal <= 1'b1;
    end else begin
      valido <= 1'b0;
      if (tmo_evt) begin
        // Timeout has priority over a coincident falling edge.
        valido    <= 1'b1;
        sem_sinal <= 1'b1;
        posicao   <= 2'b00;
        if (estado == ALTO) begin
          erro   <= 1'b1;
          // If the fall arrives on this very cycle there is nothing left to wait for.
          estado <= descida ? BAIXO : PRESO;
        end else begin
          erro <= 1'b0;
        end
      end else begin
        case (estado)
          INICIAL, BAIXO: begin
            if (subida) begin
              estado    <= ALTO;
              larg_cnt  <= N'(1);
              sem_sinal <= 1'b0;
            end
          end
          ALTO: begin
            if (descida) begin
              estado  <= BAIXO;
              largura <= larg_cnt;
              valido  <= 1'b1;
              erro    <= !casou;
              if (casou) posicao <= cod;
            end else if (larg_cnt != '1) begin
              larg_cnt <= larg_cnt + 1'b1;
            end
          end
          PRESO: begin
            if (descida) estado <= BAIXO;
          end
          default: estado <= INICIAL;
        endcase
      end
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_decodificador_servo.sv
// Self-checking bench for decodificador_servo with widths scaled down to keep runs short.
// Table vectors, randomized pulses against a window-matching model, and hand-written corner sequences.
// Works with and without DECOD_SERVO_FILTRO_EN.
module tb_decodificador_servo;

  localparam int L01 = 50;
  localparam int L10 = 75;
  localparam int L11 = 100;
  localparam int TL  = 2;
  localparam int TMO = 1100;
  localparam int NW  = 12;
  localparam int FC  = 4;
`ifdef DECOD_SERVO_FILTRO_EN
  localparam int LAT = 3 + FC;
`else
  localparam int LAT = 3;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pwm   = 1'b0;
  logic [1:0]    posicao;
  logic [NW-1:0] largura;
  logic          valido;
  logic          erro;
  logic          sem_sinal;
  logic [1:0]    db_estado;

  decodificador_servo #(
    .LARG_01(L01), .LARG_10(L10), .LARG_11(L11), .TOL(TL),
    .TIMEOUT(TMO), .N(NW), .FILTRO_CICLOS(FC)
  ) dut (
    .clock(clock), .reset(reset), .pwm(pwm),
    .posicao(posicao), .largura(largura), .valido(valido), .erro(erro),
    .sem_sinal(sem_sinal), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int v_pos  = 0;
  int v_larg = 0;
  int v_erro = 0;
  int mod_pos = 0;

  // Capture every valido strobe away from the active edge.
  always @(negedge clock) begin
    if (valido) begin
      vcount = vcount + 1;
      v_pos  = int'(posicao);
      v_larg = int'(largura);
      v_erro = int'(erro);
    end
  end

  task automatic chk(input string nome, input int atual, input int esperado);
    checks++;
    if (atual != esperado) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
    end
  endtask

  // Reference: a width decodes to the nominal whose inclusive window contains it.
  task automatic modelo(input int w, output int pos, output int er);
    int nom[3];
    int achou;
    nom = '{L01, L10, L11};
    achou = -1;
    for (int i = 0; i < 3; i++)
      if (w >= nom[i] - TL && w <= nom[i] + TL) achou = i;
    if (achou < 0) begin
      er  = 1;
      pos = mod_pos;
    end else begin
      er      = 0;
      pos     = achou + 1;
      mod_pos = pos;
    end
  endtask

  task automatic pulso(input int alto, input int baixo);
    @(negedge clock) pwm = 1'b1;
    repeat (alto) @(negedge clock);
    pwm = 1'b0;
    repeat (baixo) @(negedge clock);
  endtask

  task automatic check_pulso(input string nome, input int alto, input int baixo,
                             input int epos, input int eerr);
    int v0;
    v0 = vcount;
    pulso(alto, baixo);
    chk({nome, " valido_count"}, vcount - v0, 1);
    chk({nome, " largura"}, v_larg, alto);
    chk({nome, " posicao"}, v_pos, epos);
    chk({nome, " erro"}, v_erro, eerr);
    chk({nome, " sem_sinal"}, int'(sem_sinal), 0);
  endtask

  typedef struct {
    int alto;
    int baixo;
    int pos;
    int erro;
  } vetor_t;

  vetor_t tab[13];

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, ep, ee, a, b;

    tab = '{
      '{50, 950, 1, 0}, '{50, 950, 1, 0}, '{50, 950, 1, 0},
      '{75, 950, 2, 0}, '{102, 950, 3, 0}, '{103, 900, 3, 1},
      '{98, 900, 3, 0}, '{97, 900, 3, 1}, '{48, 900, 1, 0},
      '{52, 900, 1, 0}, '{53, 900, 1, 1}, '{73, 900, 2, 0},
      '{60, 900, 2, 1}
    };

    // Asynchronous reset values, no clock edge involved.
    #1 reset = 1'b0;
    #1;
    chk("rst posicao", int'(posicao), 0);
    chk("rst largura", int'(largura), 0);
    chk("rst valido", int'(valido), 0);
    chk("rst erro", int'(erro), 0);
    chk("rst sem_sinal", int'(sem_sinal), 1);
    chk("rst db_estado", int'(db_estado), 0);

    // No pulses at all: exactly one timeout strobe.
    @(negedge clock) reset = 1'b1;
    repeat (TMO + 10) @(negedge clock);
    chk("tmo valido_count", vcount, 1);
    chk("tmo erro", v_erro, 0);
    chk("tmo posicao", int'(posicao), 0);
    chk("tmo sem_sinal", int'(sem_sinal), 1);
    chk("tmo db_estado", int'(db_estado), 0);

    // Table vectors, including inclusive window boundaries.
    for (int i = 0; i < 13; i++) begin
      check_pulso($sformatf("tab%0d", i), tab[i].alto, tab[i].baixo, tab[i].pos, tab[i].erro);
      if (tab[i].erro == 0) mod_pos = tab[i].pos;
    end

    // Randomized widths against the model.
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(110, 40);
      b = $urandom_range(900, 100);
      modelo(a, ep, ee);
      check_pulso($sformatf("rnd%0d", i), a, b, ep, ee);
    end

    // Exact valido latency after the input falls.
    @(negedge clock) pwm = 1'b1;
    repeat (50) @(negedge clock);
    pwm = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("lat edge%0d valido", k), int'(valido), (k == LAT) ? 1 : 0);
      if (k == LAT) begin
        chk("lat largura", int'(largura), 50);
        chk("lat posicao", int'(posicao), 1);
        chk("lat erro", int'(erro), 0);
      end
    end
    repeat (900) @(negedge clock);
    mod_pos = 1;

`ifdef DECOD_SERVO_FILTRO_EN
    check_pulso("pre_glitch", 75, 100, 2, 0);
    v0 = vcount;
    @(negedge clock) pwm = 1'b1;
    repeat (2) @(negedge clock);
    pwm = 1'b0;
    repeat (300) @(negedge clock);
    chk("glitch valido_count", vcount - v0, 0);
    chk("glitch db_estado", int'(db_estado), 2);
    check_pulso("pos_glitch", 50, 900, 1, 0);
`endif

    // Stuck high: single strobe, PRESO, then recovery.
    v0 = vcount;
    @(negedge clock) pwm = 1'b1;
    repeat (1200) @(negedge clock);
    chk("preso erro", int'(erro), 1);
    chk("preso sem_sinal", int'(sem_sinal), 1);
    chk("preso posicao", int'(posicao), 0);
    chk("preso db_estado", int'(db_estado), 3);
    chk("preso valido_count", vcount - v0, 1);
    pwm = 1'b0;
    repeat (300) @(negedge clock);
    chk("preso_fim valido_count", vcount - v0, 1);
    chk("preso_fim db_estado", int'(db_estado), 2);
    mod_pos = 0;
    check_pulso("apos_preso", 75, 900, 2, 0);

    // Reset asserted in the middle of a pulse, released while still high.
    @(negedge clock) pwm = 1'b1;
    repeat (40) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_meio posicao", int'(posicao), 0);
    chk("rst_meio largura", int'(largura), 0);
    chk("rst_meio valido", int'(valido), 0);
    chk("rst_meio erro", int'(erro), 0);
    chk("rst_meio sem_sinal", int'(sem_sinal), 1);
    chk("rst_meio db_estado", int'(db_estado), 0);
    @(negedge clock) reset = 1'b1;
    v0 = vcount;
    repeat (30) @(negedge clock);
    pwm = 1'b0;
    repeat (200) @(negedge clock);
    chk("alto_no_reset valido_count", vcount - v0, 0);
    chk("alto_no_reset db_estado", int'(db_estado), 0);
    mod_pos = 0;
    check_pulso("apos_reset", 100, 900, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
